// File: rtl/chacha20_poly1305_tag_check.sv
`default_nettype none
// ============================================================================
// Module   : chacha20_poly1305_tag_check
// Brief    : AEAD decrypt-side length-block generation and constant-time
//            Poly1305 tag comparison.
// Revision : 1.0 - initial release
// ============================================================================
module chacha20_poly1305_tag_check #(
    parameter int          CMP_WIDTH    = 32,
    parameter logic [63:0] MAX_CT_BYTES = 64'h0000003fffffffc0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] rx_tag,
    input  logic         aad_we,
    input  logic         ct_we,
    input  logic [6:0]   nbytes,
    input  logic         finish,
    output logic         len_valid,
    input  logic         len_ready,
    output logic [127:0] len_block,
    input  logic [127:0] calc_tag,
    input  logic         calc_tag_valid,
    output logic         ready,
    output logic         valid,
    output logic         tag_ok,
    output logic         err
);

    localparam int c_CMP_CYCLES = 128 / CMP_WIDTH;
    localparam int c_K_W        = (c_CMP_CYCLES > 1) ? $clog2(c_CMP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACCUM    = 3'd1,
        S_LEN_OUT  = 3'd2,
        S_WAIT_TAG = 3'd3,
        S_CMP      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t             r_state_q,    w_state_d;
    logic [63:0]        r_aad_len_q,  w_aad_len_d;
    logic [63:0]        r_ct_len_q,   w_ct_len_d;
    logic [127:0]       r_rx_tag_q,   w_rx_tag_d;
    logic [127:0]       r_calc_tag_q, w_calc_tag_d;
    logic               r_diff_q,     w_diff_d;
    logic               r_err_q,      w_err_d;
    logic               r_tag_ok_q,   w_tag_ok_d;
    logic               r_ct_seen_q,  w_ct_seen_d;
    logic [c_K_W-1:0]   r_k_q,        w_k_d;

    logic [63:0]             w_aad_sum;
    logic [63:0]             w_ct_sum;
    logic [c_CMP_CYCLES-1:0] w_word_neq;

    assign w_aad_sum = r_aad_len_q + {57'd0, nbytes};
    assign w_ct_sum  = r_ct_len_q  + {57'd0, nbytes};

    // Per-word mismatch flags; the FSM folds exactly one word per cycle.
    genvar gi;
    generate
        for (gi = 0; gi < c_CMP_CYCLES; gi++) begin : g_word
            assign w_word_neq[gi] = |(r_calc_tag_q[gi*CMP_WIDTH +: CMP_WIDTH] ^
                                      r_rx_tag_q[gi*CMP_WIDTH +: CMP_WIDTH]);
        end
    endgenerate

    always_comb begin
        w_state_d    = r_state_q;
        w_aad_len_d  = r_aad_len_q;
        w_ct_len_d   = r_ct_len_q;
        w_rx_tag_d   = r_rx_tag_q;
        w_calc_tag_d = r_calc_tag_q;
        w_diff_d     = r_diff_q;
        w_err_d      = r_err_q;
        w_tag_ok_d   = r_tag_ok_q;
        w_ct_seen_d  = r_ct_seen_q;
        w_k_d        = r_k_q;

        case (r_state_q)
            S_IDLE: begin
            end
            S_ACCUM: begin
                if (aad_we && ct_we) begin
                    w_err_d = 1'b1;
                end else if (aad_we || ct_we) begin
                    if (nbytes > 7'd64) begin
                        w_err_d = 1'b1;
                    end else if (aad_we) begin
                        w_aad_len_d = w_aad_sum;
                        if (r_ct_seen_q) w_err_d = 1'b1;
                    end else begin
                        w_ct_len_d  = w_ct_sum;
                        w_ct_seen_d = 1'b1;
                        if (w_ct_sum > MAX_CT_BYTES) w_err_d = 1'b1;
                    end
                end
                if (finish) w_state_d = S_LEN_OUT;
            end
            S_LEN_OUT: begin
                if (len_ready) w_state_d = S_WAIT_TAG;
            end
            S_WAIT_TAG: begin
                if (calc_tag_valid) begin
                    w_calc_tag_d = calc_tag;
                    w_k_d        = '0;
                    w_state_d    = S_CMP;
                end
            end
            S_CMP: begin
                // Fixed-length sweep: no early exit, independent of err.
                w_diff_d = r_diff_q | w_word_neq[r_k_q];
                w_k_d    = r_k_q + c_K_W'(1);
                if (r_k_q == c_K_W'(c_CMP_CYCLES - 1)) begin
                    w_tag_ok_d = ~w_diff_d & ~r_err_q;
                    w_state_d  = S_DONE;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // start re-arms from any state, aborting the message in flight.
        if (start) begin
            w_state_d   = S_ACCUM;
            w_rx_tag_d  = rx_tag;
            w_aad_len_d = '0;
            w_ct_len_d  = '0;
            w_diff_d    = 1'b0;
            w_err_d     = 1'b0;
            w_tag_ok_d  = 1'b0;
            w_ct_seen_d = 1'b0;
            w_k_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q    <= S_IDLE;
            r_aad_len_q  <= '0;
            r_ct_len_q   <= '0;
            r_rx_tag_q   <= '0;
            r_calc_tag_q <= '0;
            r_diff_q     <= 1'b0;
            r_err_q      <= 1'b0;
            r_tag_ok_q   <= 1'b0;
            r_ct_seen_q  <= 1'b0;
            r_k_q        <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_aad_len_q  <= w_aad_len_d;
            r_ct_len_q   <= w_ct_len_d;
            r_rx_tag_q   <= w_rx_tag_d;
            r_calc_tag_q <= w_calc_tag_d;
            r_diff_q     <= w_diff_d;
            r_err_q      <= w_err_d;
            r_tag_ok_q   <= w_tag_ok_d;
            r_ct_seen_q  <= w_ct_seen_d;
            r_k_q        <= w_k_d;
        end
    end

    assign ready     = (r_state_q == S_IDLE);
    assign valid     = (r_state_q == S_DONE);
    assign len_valid = (r_state_q == S_LEN_OUT);
    assign len_block = {r_ct_len_q, r_aad_len_q};
    assign tag_ok    = r_tag_ok_q;
    assign err       = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_chacha20_poly1305_tag_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_chacha20_poly1305_tag_check
// Brief    : Randomized scoreboard bench for chacha20_poly1305_tag_check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chacha20_poly1305_tag_check;

    localparam int          c_CMP_CYCLES = 4;
    localparam logic [63:0] c_MAX        = 64'd320;
    localparam logic [127:0] c_RFC_TAG   = 128'h1ae10b594f09e26a7e902ecbd0600691;

    logic         clk = 1'b0;
    logic         reset_n, start, aad_we, ct_we, finish, len_ready, calc_tag_valid;
    logic [6:0]   nbytes;
    logic [127:0] rx_tag, calc_tag;
    logic         len_valid, ready, valid, tag_ok, err;
    logic [127:0] len_block;

    chacha20_poly1305_tag_check #(
        .CMP_WIDTH    (32),
        .MAX_CT_BYTES (c_MAX)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .rx_tag         (rx_tag),
        .aad_we         (aad_we),
        .ct_we          (ct_we),
        .nbytes         (nbytes),
        .finish         (finish),
        .len_valid      (len_valid),
        .len_ready      (len_ready),
        .len_block      (len_block),
        .calc_tag       (calc_tag),
        .calc_tag_valid (calc_tag_valid),
        .ready          (ready),
        .valid          (valid),
        .tag_ok         (tag_ok),
        .err            (err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic   tag_ok;
        logic   err;
        longint t;
    } exp_t;
    exp_t exp_q[$];

    // Reference model of the current message.
    logic [63:0]  m_aad, m_ct;
    logic [127:0] m_rx;
    bit           m_err, m_ctseen;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid pulse must match the oldest expected result.
    always @(posedge clk) begin
        #2;
        if (valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tag_ok", tag_ok, e.tag_ok);
                check("err_at_valid", err, e.err);
                check("latency", cyc - e.t, c_CMP_CYCLES);
            end
        end
    end

    task automatic do_start(input logic [127:0] tag);
        start = 1'b1;
        rx_tag = tag;
        step();
        start = 1'b0;
        m_rx = tag; m_aad = '0; m_ct = '0; m_err = 0; m_ctseen = 0;
    endtask

    task automatic do_write(input bit a, input bit c, input int n, input bit fin);
        aad_we = a; ct_we = c; nbytes = n[6:0]; finish = fin;
        step();
        aad_we = 1'b0; ct_we = 1'b0; finish = 1'b0;
        if (a && c) begin
            m_err = 1;
        end else if (a || c) begin
            if (n > 64) m_err = 1;
            else if (a) begin
                if (m_ctseen) m_err = 1;
                m_aad += 64'(n);
            end else begin
                m_ct += 64'(n);
                m_ctseen = 1;
                if (m_ct > c_MAX) m_err = 1;
            end
        end
        check("err_after_write", err, m_err);
    endtask

    task automatic do_len(input int hold);
        logic [127:0] first;
        check("len_valid_enter", len_valid, 1);
        check("len_block", len_block, {m_ct, m_aad});
        first = len_block;
        for (int i = 0; i < hold; i++) begin
            len_ready = 1'b0;
            step();
            check("len_valid_hold", len_valid, 1);
            check("len_block_hold", len_block, first);
        end
        len_ready = 1'b1;
        step();
        len_ready = 1'b0;
        check("len_transfer", len_valid, 0);
    endtask

    task automatic do_tag(input logic [127:0] ctag);
        exp_t e;
        int   w;
        calc_tag = ctag;
        calc_tag_valid = 1'b1;
        e.tag_ok = (ctag == m_rx) && !m_err;
        e.err    = m_err;
        e.t      = cyc + 1;
        exp_q.push_back(e);
        step();
        calc_tag_valid = 1'b0;
        w = 0;
        while (!ready && w < 40) begin
            step();
            w++;
        end
        check("done_in_time", ready, 1);
    endtask

    function automatic int rand_n();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 127))
                                           : int'($urandom_range(0, 64));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] tag, ctag;
        int na, nc, hold;
        bit pre;

        reset_n = 1'b0; start = 0; aad_we = 0; ct_we = 0; finish = 0;
        len_ready = 0; calc_tag_valid = 0; nbytes = '0; rx_tag = '0; calc_tag = '0;
        repeat (3) step();
        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_tag_ok", tag_ok, 0);
        check("rst_err", err, 0);
        check("rst_len_valid", len_valid, 0);
        check("rst_len_block", len_block, 0);
        reset_n = 1'b1;
        step();

        // RFC 8439 AEAD vector: matching, bit-127 flip, bit-0 flip.
        for (int v = 0; v < 3; v++) begin
            do_start(c_RFC_TAG);
            do_write(1, 0, 12, 0);
            do_write(0, 1, 64, 0);
            do_write(0, 1, 50, 0);
            do_write(0, 0, 0, 1);
            check("rfc_len_block", len_block, {64'd114, 64'd12});
            do_len((v == 1) ? 10 : 0);
            ctag = c_RFC_TAG;
            if (v == 1) ctag[127] = ~ctag[127];
            if (v == 2) ctag[0] = ~ctag[0];
            do_tag(ctag);
            check("tag_ok_held", tag_ok, (v == 0) ? 1 : 0);
        end

        // Ordering error, matching tags.
        do_start(128'h0123456789abcdef0011223344556677);
        do_write(0, 1, 16, 0);
        do_write(1, 0, 4, 0);
        check("order_err", err, 1);
        do_write(0, 0, 0, 1);
        do_len(0);
        do_tag(m_rx);

        // Simultaneous AAD/CT write.
        do_start(128'hfeedface);
        do_write(1, 0, 8, 0);
        do_write(1, 1, 16, 0);
        check("simul_len_block", len_block, {64'd0, 64'd8});
        do_write(0, 0, 0, 1);
        do_len(2);
        do_tag(m_rx);

        // Ciphertext length limit: exact max is legal, one more byte is not.
        do_start(128'h55aa);
        for (int i = 0; i < 5; i++) do_write(0, 1, 64, 0);
        check("max_ok_err", err, 0);
        do_write(0, 1, 1, 1);
        check("max_plus1_err", err, 1);
        do_len(0);
        do_tag(m_rx);

        // Asynchronous reset in the middle of the comparison.
        do_start(128'h77);
        do_write(1, 0, 3, 1);
        do_len(0);
        calc_tag = 128'h77; calc_tag_valid = 1'b1;
        step();
        calc_tag_valid = 1'b0;
        step();
        reset_n = 1'b0;
        #2;
        check("async_rst_ready", ready, 1);
        check("async_rst_valid", valid, 0);
        check("async_rst_tag_ok", tag_ok, 0);
        check("async_rst_len_block", len_block, 0);
        step();
        reset_n = 1'b1;
        step();

        // start while waiting for the tag aborts silently.
        do_start(128'h1111);
        do_write(0, 1, 40, 1);
        do_len(0);
        do_start(128'h2222);
        check("abort_cleared", len_block, 0);
        do_write(1, 0, 5, 0);
        do_write(0, 1, 7, 1);
        do_len(1);
        do_tag(128'h2222);

        // Randomized messages.
        for (int i = 0; i < 40; i++) begin
            tag = {$urandom, $urandom, $urandom, $urandom};
            do_start(tag);
            na = $urandom_range(0, 2);
            nc = $urandom_range(0, 5);
            for (int j = 0; j < na; j++) do_write(1, 0, rand_n(), 0);
            for (int j = 0; j < nc; j++) do_write(0, 1, rand_n(), 0);
            if ($urandom_range(0, 9) == 0) do_write(1, 0, rand_n(), 0);
            if ($urandom_range(0, 19) == 0) do_write(1, 1, rand_n(), 0);
            pre = ($urandom_range(0, 3) == 0);
            if (pre) len_ready = 1'b1;
            if ($urandom_range(0, 1) == 0) do_write(0, 0, 0, 1);
            else do_write(0, 1, rand_n(), 1);
            hold = pre ? 0 : int'($urandom_range(0, 3));
            do_len(hold);
            ctag = tag;
            if ($urandom_range(0, 1) == 0) ctag[$urandom_range(0, 127)] ^= 1'b1;
            do_tag(ctag);
        end

        repeat (8) step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
